// File: rtl/phy_rx_deserial_demux.sv
// rtl/phy_rx_deserial_demux.sv - serial bitstream to 4 byte lanes with COMMA-based byte alignment
// Optional PHYRX_REALIGN_EN: repeated misaligned COMMAs in ACTIVE force a return to SEARCH.
module phy_rx_deserial_demux #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned ALIGN_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_0rx,
  output logic [7:0] data_1rx,
  output logic [7:0] data_2rx,
  output logic [7:0] data_3rx,
  output logic       valid_0rx,
  output logic       valid_1rx,
  output logic       valid_2rx,
  output logic       valid_3rx,
  output logic       active,
  output logic       frame_valid
);

  localparam logic [2:0] ALIGN_CNT = ALIGN_COUNT[2:0];

  typedef enum logic [1:0] {S_SEARCH, S_ALIGN, S_ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      nsr;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      comma_cnt_q, comma_cnt_d;
  logic [1:0]      lane_ptr_q, lane_ptr_d;
  logic [3:0][7:0] lane_data_q, lane_data_d;
  logic [3:0]      lane_valid_q, lane_valid_d;
  logic            frame_valid_q, frame_valid_d;
  logic            boundary;
  logic            is_comma;
`ifdef PHYRX_REALIGN_EN
  logic [2:0]      mis_cnt_q, mis_cnt_d;
`endif

  always_comb begin
    nsr      = {sr_q[6:0], data_in};
    boundary = (bit_cnt_q == 3'd7);
    is_comma = (nsr == COMMA);
  end

  always_comb begin
    state_d       = state_q;
    sr_d          = nsr;
    bit_cnt_d     = bit_cnt_q + 3'd1;
    comma_cnt_d   = comma_cnt_q;
    lane_ptr_d    = lane_ptr_q;
    lane_data_d   = lane_data_q;
    lane_valid_d  = lane_valid_q;
    frame_valid_d = 1'b0;
`ifdef PHYRX_REALIGN_EN
    mis_cnt_d     = mis_cnt_q;
`endif
    unique case (state_q)
      S_SEARCH: begin
        // Any bit offset may match; the bit after the match is the next MSB.
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 3'd1;
          state_d     = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
            if (comma_cnt_d == ALIGN_CNT) begin
              state_d    = S_ACTIVE;
              lane_ptr_d = 2'd0;
            end
          end else begin
            state_d     = S_SEARCH;
            comma_cnt_d = 3'd0;
          end
        end
      end
      S_ACTIVE: begin
`ifdef PHYRX_REALIGN_EN
        if (mis_cnt_q >= ALIGN_CNT) begin
          state_d      = S_SEARCH;
          lane_valid_d = 4'b0000;
          lane_ptr_d   = 2'd0;
          mis_cnt_d    = 3'd0;
          comma_cnt_d  = 3'd0;
        end else begin
          if (is_comma) begin
            if (boundary) mis_cnt_d = 3'd0;
            else if (mis_cnt_q != 3'd7) mis_cnt_d = mis_cnt_q + 3'd1;
          end
`endif
          if (boundary) begin
            if (is_comma) begin
              // An idle byte mid-frame drops the partial frame.
              lane_valid_d = 4'b0000;
              lane_ptr_d   = 2'd0;
            end else begin
              lane_data_d[lane_ptr_q]  = nsr;
              lane_valid_d[lane_ptr_q] = 1'b1;
              lane_ptr_d               = lane_ptr_q + 2'd1;
              if (lane_ptr_q == 2'd3) frame_valid_d = 1'b1;
            end
          end
`ifdef PHYRX_REALIGN_EN
        end
`endif
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q       <= S_SEARCH;
      sr_q          <= 8'h00;
      bit_cnt_q     <= 3'd0;
      comma_cnt_q   <= 3'd0;
      lane_ptr_q    <= 2'd0;
      lane_data_q   <= '0;
      lane_valid_q  <= 4'b0000;
      frame_valid_q <= 1'b0;
`ifdef PHYRX_REALIGN_EN
      mis_cnt_q     <= 3'd0;
`endif
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      comma_cnt_q   <= comma_cnt_d;
      lane_ptr_q    <= lane_ptr_d;
      lane_data_q   <= lane_data_d;
      lane_valid_q  <= lane_valid_d;
      frame_valid_q <= frame_valid_d;
`ifdef PHYRX_REALIGN_EN
      mis_cnt_q     <= mis_cnt_d;
`endif
    end
  end

  assign data_0rx    = lane_data_q[0];
  assign data_1rx    = lane_data_q[1];
  assign data_2rx    = lane_data_q[2];
  assign data_3rx    = lane_data_q[3];
  assign valid_0rx   = lane_valid_q[0];
  assign valid_1rx   = lane_valid_q[1];
  assign valid_2rx   = lane_valid_q[2];
  assign valid_3rx   = lane_valid_q[3];
  assign active      = (state_q == S_ACTIVE);
  assign frame_valid = frame_valid_q;

endmodule
